// File: rtl/qpsk_symbol_scheduler_pkg.sv
// Shared constants and types for the QPSK symbol scheduler.
// Holds the DDS timing constants of the modulator, the symbol type and the
// scheduler state enumeration.
package qpsk_pkg;

    localparam int unsigned CLK_HZ            = 50000000;
    localparam int unsigned DDS_3HZ_INCREMENT = 258;

    // Counts at which the phase-shifted DDS generators are started.
    localparam int unsigned GEN1_START = 4166666;
    localparam int unsigned GEN2_START = 8333333;
    localparam int unsigned GEN3_START = 12500000;

    // Default warm-up covers the last generator start count.
    localparam int unsigned STARTUP_CYCLES_DEFAULT = GEN3_START + 1;

    typedef logic [1:0] qpsk_sym_t;

    typedef enum logic [1:0] {
        WARMUP,
        IDLE,
        RUN
    } sched_state_t;

endpackage

// File: rtl/qpsk_symbol_scheduler_if.sv
// Symbol handshake between the upstream source and the scheduler.
//   sym_in    : {I,Q} symbol
//   sym_valid : sym_in valid
//   sym_ready : scheduler buffer can accept; push when valid && ready
interface qpsk_symbol_scheduler_if;
    import qpsk_pkg::*;

    qpsk_sym_t sym_in;
    logic      sym_valid;
    logic      sym_ready;

    modport master (output sym_in, output sym_valid, input sym_ready);
    modport slave  (input sym_in, input sym_valid, output sym_ready);

endinterface

// File: rtl/qpsk_symbol_scheduler_sync_fifo.sv
// Synchronous FIFO used as the scheduler's symbol buffer.
//   clk, reset : clock, synchronous active-high reset (discards contents)
//   push       : write push_data (ignored when full)
//   pop        : advance the head (ignored when empty)
//   pop_data   : current head entry
//   count      : number of stored entries
//   full/empty : derived from the registered count
module sync_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// Sequences buffered QPSK symbols onto the modulator IQ select input.
// Waits out the DDS generator start-up, then issues one symbol per symbol
// period, substituting IDLE_SYMBOL on underflow or stop.
//   clk, reset    : clock, synchronous active-high reset
//   sym_bus       : upstream valid/ready symbol handshake (slave side)
//   enable        : request transmission
//   clr_underflow : clear the sticky underflow flag
//   iq            : registered symbol select to the modulator
//   sym_strobe    : one-cycle pulse when iq takes a new value
//   underflow     : sticky, set when a boundary finds the buffer empty
//   fill          : buffered symbol count
//   busy          : high in WARMUP and RUN
module qpsk_symbol_scheduler
    import qpsk_pkg::*;
#(
    parameter int unsigned CLK_HZ         = qpsk_pkg::CLK_HZ,
    parameter int unsigned SYMBOL_PERIOD  = (CLK_HZ + 2) / 3,
    parameter int unsigned STARTUP_CYCLES = STARTUP_CYCLES_DEFAULT,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter qpsk_sym_t   IDLE_SYMBOL    = 2'b00
) (
    input  logic                        clk,
    input  logic                        reset,
    qpsk_symbol_scheduler_if.slave      sym_bus,
    input  logic                        enable,
    input  logic                        clr_underflow,
    output qpsk_sym_t                   iq,
    output logic                        sym_strobe,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fill,
    output logic                        busy
);

    localparam int unsigned PER_W  = $clog2(SYMBOL_PERIOD);
    localparam int unsigned WARM_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SYMBOL_PERIOD - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STARTUP_CYCLES - 1);

    sched_state_t      state;
    logic [PER_W-1:0]  period_cnt;
    logic [WARM_W-1:0] warm_cnt;

    qpsk_sym_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    logic      boundary;

    assign sym_bus.sym_ready = !fifo_full;
    assign fifo_push         = sym_bus.sym_valid && !fifo_full;
    assign boundary          = (state == RUN) && (period_cnt == PER_LAST);
    // Empty comes from the registered count, so a push in this cycle is
    // never popped in the same cycle.
    assign fifo_pop          = enable && !fifo_empty && ((state == IDLE) || boundary);
    assign busy              = (state != IDLE);

    sync_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (sym_bus.sym_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fill),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WARMUP;
            warm_cnt   <= '0;
            period_cnt <= '0;
            iq         <= IDLE_SYMBOL;
            sym_strobe <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            // Placed before any set so a simultaneous set wins.
            if (clr_underflow) begin
                underflow <= 1'b0;
            end
            case (state)
                WARMUP: begin
                    iq <= IDLE_SYMBOL;
                    if (warm_cnt == WARM_LAST) begin
                        state <= IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (fifo_pop) begin
                        iq         <= fifo_head;
                        sym_strobe <= 1'b1;
                        period_cnt <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        period_cnt <= '0;
                        sym_strobe <= 1'b1;
                        if (!enable) begin
                            iq    <= IDLE_SYMBOL;
                            state <= IDLE;
                        end else if (fifo_pop) begin
                            iq <= fifo_head;
                        end else begin
                            iq        <= IDLE_SYMBOL;
                            underflow <= 1'b1;
                        end
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Self-checking bench for qpsk_symbol_scheduler with a short symbol period,
// short warm-up and a 4-entry buffer. A vector table covers warm-up and
// underflow, hand sequences cover streaming, backpressure, stop and reset,
// and a randomized phase is checked against a cycle-numbered reference model.
module tb_qpsk_symbol_scheduler;
    import qpsk_pkg::*;

    localparam int SP = 4;
    localparam int SC = 6;
    localparam int FD = 4;
    localparam qpsk_sym_t IDLE_SYM = 2'b00;

    localparam int M_WARM = 0;
    localparam int M_IDLE = 1;
    localparam int M_RUN  = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clr_underflow;
    qpsk_sym_t  iq;
    logic       sym_strobe;
    logic       underflow;
    logic [2:0] fill;
    logic       busy;

    qpsk_symbol_scheduler_if bus ();

    qpsk_symbol_scheduler #(
        .SYMBOL_PERIOD  (SP),
        .STARTUP_CYCLES (SC),
        .FIFO_DEPTH     (FD),
        .IDLE_SYMBOL    (IDLE_SYM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sym_bus       (bus.slave),
        .enable        (enable),
        .clr_underflow (clr_underflow),
        .iq            (iq),
        .sym_strobe    (sym_strobe),
        .underflow     (underflow),
        .fill          (fill),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: absolute cycle numbering, a queue for the buffer.
    qpsk_sym_t m_q[$];
    int        m_mode;
    int        m_cyc;
    int        m_origin;
    qpsk_sym_t m_iq;
    bit        m_st;
    bit        m_uf;

    function automatic void model_update(input logic r, input logic v, input qpsk_sym_t d,
                                         input logic en, input logic clr);
        int size;
        bit take;
        if (r) begin
            m_q.delete();
            m_mode = M_WARM;
            m_cyc  = 0;
            m_iq   = IDLE_SYM;
            m_st   = 0;
            m_uf   = 0;
            return;
        end
        size = m_q.size();
        take = v && (size < FD);
        m_st = 0;
        if (clr) m_uf = 0;
        case (m_mode)
            M_WARM: if (m_cyc == SC - 1) m_mode = M_IDLE;
            M_IDLE: begin
                if (en && size > 0) begin
                    m_iq     = m_q.pop_front();
                    m_st     = 1;
                    m_origin = m_cyc;
                    m_mode   = M_RUN;
                end
            end
            default: begin
                // Symbols start every SP cycles measured from the first pop.
                if ((m_cyc - m_origin) % SP == 0) begin
                    m_st = 1;
                    if (!en) begin
                        m_iq   = IDLE_SYM;
                        m_mode = M_IDLE;
                    end else if (size > 0) begin
                        m_iq = m_q.pop_front();
                    end else begin
                        m_iq = IDLE_SYM;
                        m_uf = 1;
                    end
                end
            end
        endcase
        if (take) m_q.push_back(d);
        m_cyc++;
    endfunction

    task automatic step(input logic r, input logic v, input qpsk_sym_t d,
                        input logic en, input logic clr);
        reset         = r;
        bus.sym_valid = v;
        bus.sym_in    = d;
        enable        = en;
        clr_underflow = clr;
        model_update(r, v, d, en, clr);
        @(posedge clk);
        #1;
        chk("iq",         int'(iq),            int'(m_iq));
        chk("sym_strobe", int'(sym_strobe),    int'(m_st));
        chk("underflow",  int'(underflow),     int'(m_uf));
        chk("fill",       int'(fill),          m_q.size());
        chk("sym_ready",  int'(bus.sym_ready), int'(m_q.size() != FD));
        chk("busy",       int'(busy),          int'(m_mode != M_IDLE));
    endtask

    typedef struct {
        logic      rst;
        logic      v;
        qpsk_sym_t d;
        logic      en;
        logic      clr;
        qpsk_sym_t e_iq;
        logic      e_st;
        logic      e_uf;
        int        e_fill;
        logic      e_busy;
        logic      e_rdy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset         = 1'b1;
        enable        = 1'b0;
        clr_underflow = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_in    = 2'b00;

        // Warm-up, first symbol, underflow, clear.
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1};

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].rst, tbl[k].v, tbl[k].d, tbl[k].en, tbl[k].clr);
            chk($sformatf("tbl%0d_iq", k),    int'(iq),            int'(tbl[k].e_iq));
            chk($sformatf("tbl%0d_st", k),    int'(sym_strobe),    int'(tbl[k].e_st));
            chk($sformatf("tbl%0d_uf", k),    int'(underflow),     int'(tbl[k].e_uf));
            chk($sformatf("tbl%0d_fill", k),  int'(fill),          tbl[k].e_fill);
            chk($sformatf("tbl%0d_busy", k),  int'(busy),          int'(tbl[k].e_busy));
            chk($sformatf("tbl%0d_ready", k), int'(bus.sym_ready), int'(tbl[k].e_rdy));
        end

        // Backpressure, streaming and stop.
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < SC; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, qpsk_sym_t'(i % 4), 1'b0, 1'b0);
        chk("bp_fill_full", int'(fill), 4);
        chk("bp_ready_low", int'(bus.sym_ready), 0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("bp_ready_after_pop", int'(bus.sym_ready), 1);
        chk("stream_first_iq", int'(iq), 0);
        for (int i = 0; i < 2 * SP; i++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("stream_third_iq", int'(iq), 2);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("stop_holds_iq", int'(iq), 2);
        for (int i = 1; i < SP; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("stop_iq_idle", int'(iq), 0);
        chk("stop_not_busy", int'(busy), 0);
        chk("stop_fill_kept", int'(fill), 1);

        // Reset in RUN with three symbols buffered.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, qpsk_sym_t'(i + 1), 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("rst_pre_fill", int'(fill), 3);
        step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_iq", int'(iq), 0);
        chk("rst_busy", int'(busy), 1);
        for (int i = 0; i < SC - 1; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("rst_warm_busy", int'(busy), 1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("rst_warm_done", int'(busy), 0);

        // Underflow set coinciding with clr_underflow: set wins.
        step(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
            if (sym_strobe && iq == IDLE_SYM) found = 1;
        end
        chk("set_wins_seen", int'(found), 1);
        chk("set_wins_uf", int'(underflow), 1);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("clear_uf", int'(underflow), 0);
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < SP; i++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 1),
                 1'($urandom_range(0, 1)),
                 qpsk_sym_t'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 8));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_scheduler.md
Name: qpsk_symbol_scheduler

Overview:
Sequences 2-bit QPSK symbols into the QPSK modulator's IQ select input. The block buffers symbols from an upstream source (LFSR pair or Nios/Qsys slave) through a valid/ready handshake. It holds off output until all four phase-shifted DDS generators in the modulator are running. It then presents one symbol per fixed symbol period and substitutes an idle symbol on underflow or stop.

Parameters:
CLK_HZ, 50000000, system clock frequency; documentation and derived defaults only
SYMBOL_PERIOD, 16666667, clk cycles per symbol (one 3 Hz carrier period at 50 MHz); must be >= 2
STARTUP_CYCLES, 12500001, cycles after reset before any symbol is issued (covers last generator start at count 12500000)
FIFO_DEPTH, 8, symbol buffer entries; power of 2, >= 2
IDLE_SYMBOL, 2'b00, IQ value driven when no symbol is active

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sym_in  in  2  upstream symbol {I,Q}
sym_valid  in  1  sym_in valid
sym_ready  out  1  buffer can accept; a push occurs when sym_valid && sym_ready
enable  in  1  request transmission
clr_underflow  in  1  clears the sticky underflow flag
iq  out  2  symbol select to the modulator IQ input (registered)
sym_strobe  out  1  one-cycle pulse in the cycle iq takes a new value
underflow  out  1  sticky; set when a boundary finds the buffer empty while enable=1
fill  out  $clog2(FIFO_DEPTH)+1  buffered symbol count
busy  out  1  high in WARMUP and RUN

Behaviour:
- Reset values: iq=IDLE_SYMBOL, sym_strobe=0, underflow=0, fill=0, state=WARMUP, period counter=0, warm-up counter=0. sym_ready is 1 after reset (buffer empty).
- Buffer: synchronous FIFO. sym_ready = (fill != FIFO_DEPTH), computed from the registered count. When full, no push is accepted even if a pop occurs in the same cycle. A push and a pop in the same cycle leave fill unchanged. Pushes are accepted in every state, including WARMUP.
- WARMUP: counts 0..STARTUP_CYCLES-1, then moves to IDLE. Entered only from reset. iq=IDLE_SYMBOL throughout.
- IDLE: iq=IDLE_SYMBOL. When enable && fill!=0:
  - pop the head, load it into iq, pulse sym_strobe;
  - set period counter to 0 and go to RUN.
- RUN: the period counter counts 0..SYMBOL_PERIOD-1. The boundary is the cycle with counter==SYMBOL_PERIOD-1; the counter wraps to 0 in that cycle. At the boundary:
  - enable && fill!=0: pop, load the new head into iq, pulse sym_strobe, stay in RUN;
  - enable && fill==0: iq<=IDLE_SYMBOL, pulse sym_strobe, set underflow, stay in RUN (period timing is preserved);
  - !enable: iq<=IDLE_SYMBOL, pulse sym_strobe, go to IDLE.
- Deasserting enable mid-symbol has no effect until the boundary; the current symbol always completes.
- Latency: a symbol pushed at cycle t is eligible for a pop no earlier than t+1. A push in the boundary cycle into an empty buffer is not seen, so that boundary underflows.
- underflow: cleared by reset or clr_underflow. If a set and a clear occur in the same cycle, set wins.
- Reset asserted in any state returns all registers to their reset values next cycle, discards buffer contents, and restarts WARMUP.

Decomposition:
- Package qpsk_pkg holds:
  - localparams CLK_HZ, DDS_3HZ_INCREMENT (258) and the generator start counts (4166666, 8333333, 12500000);
  - typedef qpsk_sym_t (logic [1:0]);
  - enum sched_state_t {WARMUP, IDLE, RUN}.
- STARTUP_CYCLES and SYMBOL_PERIOD defaults derive from the package constants.
- One sub-module: sync_fifo (parameterised width/depth, push/pop, count, full/empty) holds the buffer. The scheduler FSM and counters stay in the top module.

Test Plan:
All scenarios use SYMBOL_PERIOD=4, STARTUP_CYCLES=6, FIFO_DEPTH=4.
1. Warm-up: reset for 2 cycles, enable=1, push 0b01 at cycle 1 -> iq=00 and busy=1 for 6 cycles; first strobe 1 cycle after WARMUP exits with iq=01.
2. Streaming: preload 00,01,10,11 then enable -> iq steps 00,01,10,11, each held exactly 4 cycles; strobes 4 cycles apart; fill ends at 0.
3. Underflow: one symbol 11 queued, enable held -> iq=11 for 4 cycles, then iq=00 with underflow=1; clr_underflow pulse -> underflow=0; a new push resumes at the next boundary.
4. Backpressure: sym_valid held with enable=0 -> exactly 4 pushes accepted, sym_ready=0 and fill=4; enable -> sym_ready returns to 1 the cycle after the first pop.
5. Stop: drop enable 1 cycle into symbol 10 -> iq stays 10 until the boundary, then iq=00 and IDLE; remaining symbols retained in fill.
6. Reset mid-RUN with fill=3 -> next cycle: fill=0, iq=00, underflow=0, WARMUP restarts for 6 cycles.
